// File: rtl/fifo_uart_tx.sv
// UART transmit stage: pops one byte from the upstream fifo per frame and serialises it
// as start, DATA_W data bits LSB-first, optional parity, then STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                parity_q;
  logic                tx_q;
  logic                busy_q;
  logic                frame_done_q;

  logic                baud_wrap;
  logic [BAUD_W-1:0]   baud_d;
  logic                parity_d;

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign baud_d    = baud_wrap ? '0 : baud_q + 1'b1;
  // Parity is captured with the byte so the data shift can be destructive.
  assign parity_d  = (PARITY == 2) ? ~(^in_data_i) : (^in_data_i);

  assign in_ready_o   = (state_q == S_IDLE) && rst_n_i;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          bit_q  <= '0;
          if (in_valid_i) begin
            state_q  <= S_START;
            shift_q  <= in_data_i;
            parity_q <= parity_d;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end

        S_DATA: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end

        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q <= S_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end

        S_STOP: begin
          baud_q <= baud_d;
          tx_q   <= 1'b1;
          // Registered pulse: raised one cycle early so it lands on the final stop cycle.
          if ((bit_q == STOP_LAST) && (baud_q == BAUD_PENULT)) begin
            frame_done_q <= 1'b1;
          end
          if (baud_wrap) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              bit_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances cover no parity, even, odd and two stop bits.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vld;
  logic [7:0] din [4];
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int vectors = 0;
  int errs    = 0;
  int pops     [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(vld[0]), .in_data_i(din[0]),
    .in_ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(busy[0]), .frame_done_o(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(vld[1]), .in_data_i(din[1]),
    .in_ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(busy[1]), .frame_done_o(done[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(vld[2]), .in_data_i(din[2]),
    .in_ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(busy[2]), .frame_done_o(done[2]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(vld[3]), .in_data_i(din[3]),
    .in_ready_o(rdy[3]), .tx_o(tx[3]), .busy_o(busy[3]), .frame_done_o(done[3]));

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (vld[d] === 1'b1 && rdy[d] === 1'b1) pops[d]++;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (done[d] === 1'b1) done_cnt[d]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the idle cycle that accepts the byte (cycle 0). lvl holds the line level of
  // each bit slot, slot 0 (start) in bit 0. Returns in the first idle cycle after the frame.
  task automatic frame(input int d, input logic [7:0] byt, input logic [15:0] lvl,
                       input int nbits, input logic nv, input logic [7:0] nd, input string tag);
    int n;
    n = nbits * 4;
    chk({tag, " ready_c0"}, 32'(rdy[d]), 32'd1);
    vld[d] = 1'b1;
    din[d] = byt;
    tick();
    vld[d] = nv;
    din[d] = nv ? nd : ~byt;
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s tx_c%0d", tag, c), 32'(tx[d]), 32'(lvl[(c - 1) / 4]));
      chk($sformatf("%s busy_c%0d", tag, c), 32'(busy[d]), 32'd1);
      chk($sformatf("%s done_c%0d", tag, c), 32'(done[d]), 32'(c == n));
      chk($sformatf("%s rdy_c%0d", tag, c), 32'(rdy[d]), 32'd0);
      tick();
    end
    chk({tag, " idle_tx"}, 32'(tx[d]), 32'd1);
    chk({tag, " idle_busy"}, 32'(busy[d]), 32'd0);
    chk({tag, " idle_done"}, 32'(done[d]), 32'd0);
    chk({tag, " idle_rdy"}, 32'(rdy[d]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = 4'hF;
    for (int d = 0; d < 4; d++) din[d] = 8'h5A;

    // Reset held with valid asserted: line idle, nothing popped.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst tx_%0d", i), 32'(tx), 32'hF);
      chk($sformatf("rst busy_%0d", i), 32'(busy), 32'h0);
      chk($sformatf("rst rdy_%0d", i), 32'(rdy), 32'h0);
      chk($sformatf("rst done_%0d", i), 32'(done), 32'h0);
    end
    chk("rst pops", 32'(pops[0] + pops[1] + pops[2] + pops[3]), 32'd0);
    vld   = 4'h0;
    rst_n = 1'b1;
    tick();
    chk("post_rst rdy", 32'(rdy), 32'hF);
    chk("post_rst tx", 32'(tx), 32'hF);

    // Single byte 0x09, no parity, one stop bit.
    frame(0, 8'h09, {1'b1, 8'h09, 1'b0}, 10, 1'b0, 8'h00, "single09");
    chk("single09 pops", 32'(pops[0]), 32'd1);
    tick();
    tick();
    chk("idle_hold tx", 32'(tx[0]), 32'd1);
    chk("idle_hold rdy", 32'(rdy[0]), 32'd1);

    // Back-to-back stream with valid held: 41-cycle period.
    frame(0, 8'h09, {1'b1, 8'h09, 1'b0}, 10, 1'b1, 8'h2D, "strm09");
    frame(0, 8'h2D, {1'b1, 8'h2D, 1'b0}, 10, 1'b1, 8'h0A, "strm2D");
    frame(0, 8'h0A, {1'b1, 8'h0A, 1'b0}, 10, 1'b0, 8'h00, "strm0A");
    chk("strm pops", 32'(pops[0]), 32'd4);
    chk("strm dones", 32'(done_cnt[0]), 32'd4);

    // Parity frames: {stop, parity, data, start}.
    frame(1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 8'h00, "even07");
    frame(2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 8'h00, "odd07");
    frame(1, 8'h09, {1'b1, 1'b0, 8'h09, 1'b0}, 11, 1'b0, 8'h00, "even09");

    // Two stop bits.
    frame(3, 8'hFF, {2'b11, 8'hFF, 1'b0}, 11, 1'b0, 8'h00, "stop2FF");

    // Reset during data bit 3 of 0x55 (cycles 17..20).
    chk("abort rdy_c0", 32'(rdy[0]), 32'd1);
    vld[0] = 1'b1;
    din[0] = 8'h55;
    tick();
    vld[0] = 1'b0;
    din[0] = 8'h00;
    for (int i = 0; i < 17; i++) tick();
    chk("abort tx_bit3", 32'(tx[0]), 32'd0);
    chk("abort busy_bit3", 32'(busy[0]), 32'd1);
    rst_n  = 1'b0;
    vld[0] = 1'b1;
    #1;
    chk("abort rdy_in_rst", 32'(rdy[0]), 32'd0);
    tick();
    chk("abort tx", 32'(tx[0]), 32'd1);
    chk("abort busy", 32'(busy[0]), 32'd0);
    chk("abort done", 32'(done[0]), 32'd0);
    vld[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort rdy_release", 32'(rdy[0]), 32'd1);
    frame(0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00, "afterA5");

    tick();
    chk("final pops0", 32'(pops[0]), 32'd6);
    chk("final dones0", 32'(done_cnt[0]), 32'd5);
    chk("final pops1", 32'(pops[1]), 32'd2);
    chk("final dones1", 32'(done_cnt[1]), 32'd2);
    chk("final pops2", 32'(pops[2]), 32'd1);
    chk("final dones2", 32'(done_cnt[2]), 32'd1);
    chk("final pops3", 32'(pops[3]), 32'd1);
    chk("final dones3", 32'(done_cnt[3]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
